// File: rtl/image_reader_master_if.sv
// Bus bundle for image_reader_master: Avalon-MM read port toward the image RAM
// plus the valid/ready pixel stream toward the datapath.
interface image_reader_master_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
) ();
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_clken;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output mem_address, mem_chipselect, mem_clken, mem_write, mem_writedata,
        input  mem_readdata,
        output out_data, out_valid, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_clken, mem_write, mem_writedata,
        output mem_readdata,
        input  out_data, out_valid, out_last,
        output out_ready
    );
endinterface

// File: rtl/image_reader_master.sv
// Avalon-MM read master streaming a run of pixels from image RAM; a credit-gated
// FIFO soaks up read latency so downstream backpressure never drops a pixel.
module image_reader_master #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 8,
    parameter int NUM_PIXELS   = 81920,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] pixel_count,
    output logic              busy,
    output logic              done,
    image_reader_master_if.master bus
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + READ_LATENCY + 2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_reg;
    logic [ADDR_W-1:0]       addr_reg;
    logic [CNT_W-1:0]        count_reg;
    logic [CNT_W-1:0]        issued_reg;
    logic [CNT_W-1:0]        beats_reg;
    logic                    cs_reg;
    logic                    clken_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic [READ_LATENCY-1:0] flight_reg;
    logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [OCC_W-1:0]        occ_reg;

    logic              push;
    logic              pop;
    logic              fifo_valid;
    logic              last_beat;
    logic              can_issue;
    logic [OCC_W-1:0]  in_flight;
    logic [ADDR_W-1:0] addr_inc;

    // Reads outstanding: the one on the bus now plus those still in the latency pipe.
    always_comb begin
        in_flight = OCC_W'(cs_reg);
        for (int i = 0; i < READ_LATENCY; i++) begin
            in_flight = in_flight + OCC_W'(flight_reg[i]);
        end
    end

    assign push       = flight_reg[READ_LATENCY-1];
    assign fifo_valid = (occ_reg != '0);
    assign pop        = fifo_valid & bus.out_ready;
    assign last_beat  = (beats_reg == count_reg - CNT_W'(1));
    assign can_issue  = (issued_reg < count_reg) &&
                        ((occ_reg + in_flight) < OCC_W'(FIFO_DEPTH));
    assign addr_inc   = (addr_reg == ADDR_W'(NUM_PIXELS - 1)) ? '0 : addr_reg + 1'b1;

    assign busy               = busy_reg;
    assign done               = done_reg;
    assign bus.mem_address    = addr_reg;
    assign bus.mem_chipselect = cs_reg;
    assign bus.mem_clken      = clken_reg;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_writedata  = '0;
    assign bus.out_valid      = fifo_valid;
    assign bus.out_data       = fifo_valid ? fifo_mem[rd_ptr_reg] : '0;
    assign bus.out_last       = fifo_valid & last_beat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            count_reg  <= '0;
            issued_reg <= '0;
            beats_reg  <= '0;
            cs_reg     <= 1'b0;
            clken_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            clken_reg <= 1'b1;
            done_reg  <= 1'b0;
            cs_reg    <= 1'b0;
            if (abort) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end else begin
                if (pop) beats_reg <= beats_reg + 1'b1;
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            if (pixel_count == '0) begin
                                done_reg <= 1'b1;
                            end else begin
                                state_reg  <= RUN;
                                busy_reg   <= 1'b1;
                                addr_reg   <= base_addr;
                                count_reg  <= {1'b0, pixel_count};
                                issued_reg <= CNT_W'(1);
                                beats_reg  <= '0;
                                cs_reg     <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (issued_reg == count_reg) begin
                            state_reg <= DRAIN;
                        end else if (can_issue) begin
                            cs_reg     <= 1'b1;
                            addr_reg   <= addr_inc;
                            issued_reg <= issued_reg + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (pop && last_beat) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // Issue flag delayed by the read latency marks when mem_readdata is valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flight_reg <= '0;
        end else if (abort) begin
            flight_reg <= '0;
        end else begin
            flight_reg[0] <= cs_reg;
            for (int i = 1; i < READ_LATENCY; i++) begin
                flight_reg[i] <= flight_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else if (abort) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            occ_reg <= occ_reg + OCC_W'(push) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= bus.mem_readdata;
    end
endmodule

// File: tb/tb_image_reader_master.sv
// Directed bench for image_reader_master against a 1-cycle-latency memory model
// holding mem[a] = a[7:0].
module tb_image_reader_master;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 8;
    localparam int NPIX   = 81920;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] pixel_count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr_q;

    image_reader_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    image_reader_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_PIXELS(NPIX),
        .READ_LATENCY(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .base_addr(base_addr), .pixel_count(pixel_count),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    // Memory slave: address registered on the edge, unregistered q.
    always @(posedge clk) if (bus.mem_clken) mem_addr_q <= bus.mem_address;
    assign bus.mem_readdata = mem_addr_q[7:0];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int unsigned got_q[$];
    int unsigned last_q[$];
    int unsigned acc_cyc[$];
    int unsigned addr_log[$];
    int done_cnt = 0;
    int valid_cnt = 0;
    int last_cyc = 0;
    int done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.out_data);
            last_q.push_back(bus.out_last);
            acc_cyc.push_back(cyc);
            if (bus.out_last) last_cyc = cyc;
        end
        if (bus.out_valid) valid_cnt++;
        if (bus.mem_chipselect) addr_log.push_back(bus.mem_address);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        got_q.delete();
        last_q.delete();
        acc_cyc.delete();
        addr_log.delete();
        done_cnt = 0;
        valid_cnt = 0;
    endtask

    task automatic do_start(input int unsigned b, input int unsigned c);
        start = 1'b1;
        base_addr = b[ADDR_W-1:0];
        pixel_count = c[ADDR_W-1:0];
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick(1);
            n++;
        end
        check_eq({tag, "_done_seen"}, int'(done_cnt != 0), 1);
    endtask

    task automatic wait_beats(input string tag, input int beats, input int budget);
        int n = 0;
        while (got_q.size() < beats && n < budget) begin
            tick(1);
            n++;
        end
        check_eq({tag, "_beats_reached"}, int'(got_q.size() >= beats), 1);
    endtask

    task automatic check_stream(input string tag, input int unsigned b, input int unsigned c);
        check_eq({tag, "_len"}, got_q.size(), c);
        for (int i = 0; i < got_q.size() && i < c; i++) begin
            check_eq($sformatf("%s_data%0d", tag, i), got_q[i], ((b + i) % NPIX) & 8'hFF);
        end
    endtask

    initial begin
        int unsigned lsum;
        int unsigned wrap_addr [4];
        int vsnap;
        wrap_addr[0] = 81918; wrap_addr[1] = 81919; wrap_addr[2] = 0; wrap_addr[3] = 1;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; pixel_count = '0; bus.out_ready = 1'b1;
        #3;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cs", bus.mem_chipselect, 0);
        check_eq("rst_clken", bus.mem_clken, 0);
        check_eq("rst_valid", bus.out_valid, 0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        check_eq("clken_on", bus.mem_clken, 1);
        check_eq("write_zero", bus.mem_write, 0);

        // Basic run of four pixels.
        clear_logs();
        do_start(32'h10, 4);
        check_eq("t1_cs_first", bus.mem_chipselect, 1);
        check_eq("t1_addr_first", bus.mem_address, 32'h10);
        check_eq("t1_busy", busy, 1);
        check_eq("t1_valid_e0", bus.out_valid, 0);
        tick(1);
        check_eq("t1_valid_e1", bus.out_valid, 0);
        tick(1);
        check_eq("t1_valid_e2", bus.out_valid, 1);
        check_eq("t1_data_e2", bus.out_data, 32'h10);
        wait_done("t1", 40);
        check_stream("t1", 32'h10, 4);
        lsum = 0;
        foreach (last_q[i]) lsum += last_q[i];
        check_eq("t1_last_count", lsum, 1);
        if (last_q.size() == 4) check_eq("t1_last_pos", last_q[3], 1);
        check_eq("t1_done_delay", done_cyc - last_cyc, 1);
        if (acc_cyc.size() == 4) check_eq("t1_no_bubble", acc_cyc[3] - acc_cyc[0], 3);
        check_eq("t1_busy_end", busy, 0);

        // Address wrap at the top of memory.
        clear_logs();
        do_start(81918, 4);
        wait_done("t2", 40);
        check_eq("t2_addr_len", addr_log.size(), 4);
        for (int i = 0; i < addr_log.size() && i < 4; i++)
            check_eq($sformatf("t2_addr%0d", i), addr_log[i], wrap_addr[i]);
        check_stream("t2", 81918, 4);

        // Backpressure: stall five cycles after the third beat.
        clear_logs();
        do_start(32'h20, 16);
        wait_beats("t3", 3, 40);
        bus.out_ready = 1'b0;
        tick(4);
        check_eq("t3_cs_stopped", bus.mem_chipselect, 0);
        check_eq("t3_stall_valid", bus.out_valid, 1);
        check_eq("t3_stall_data", bus.out_data, 32'h23);
        tick(1);
        bus.out_ready = 1'b1;
        wait_done("t3", 80);
        check_eq("t3_issue_count", addr_log.size(), 16);
        check_stream("t3", 32'h20, 16);

        // Zero-length run.
        clear_logs();
        do_start(32'h5, 0);
        check_eq("t4_done", done, 1);
        check_eq("t4_busy", busy, 0);
        tick(4);
        check_eq("t4_no_cs", addr_log.size(), 0);
        check_eq("t4_no_valid", valid_cnt, 0);
        check_eq("t4_done_once", done_cnt, 1);

        // Abort mid-run, then a short clean run.
        clear_logs();
        do_start(32'h0, 20);
        wait_beats("t5", 5, 40);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check_eq("t5_busy", busy, 0);
        check_eq("t5_valid", bus.out_valid, 0);
        check_eq("t5_cs", bus.mem_chipselect, 0);
        vsnap = valid_cnt;
        tick(6);
        check_eq("t5_no_done", done_cnt, 0);
        check_eq("t5_no_valid_after", valid_cnt - vsnap, 0);
        clear_logs();
        do_start(32'h0, 2);
        wait_done("t5b", 40);
        check_stream("t5b", 32'h0, 2);

        // Asynchronous reset mid-run.
        clear_logs();
        do_start(32'h40, 10);
        tick(3);
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_cs", bus.mem_chipselect, 0);
        check_eq("t6_rst_valid", bus.out_valid, 0);
        check_eq("t6_rst_addr", bus.mem_address, 0);
        check_eq("t6_rst_clken", bus.mem_clken, 0);
        check_eq("t6_rst_last", bus.out_last, 0);
        tick(1);
        reset_n = 1'b1;
        tick(1);

        // Start while busy is ignored.
        clear_logs();
        do_start(32'h50, 3);
        tick(1);
        do_start(32'h60, 5);
        wait_done("t7", 40);
        check_eq("t7_addr_len", addr_log.size(), 3);
        for (int i = 0; i < addr_log.size() && i < 3; i++)
            check_eq($sformatf("t7_addr%0d", i), addr_log[i], 32'h50 + i);
        check_stream("t7", 32'h50, 3);
        tick(8);
        check_eq("t7_done_once", done_cnt, 1);
        check_eq("t7_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/image_reader_master.md
# image_reader_master

Avalon-MM read master that fetches a run of 8-bit pixels from an on-chip image memory slave (81920 x 8, single-port, fixed read latency) and presents them as a valid/ready pixel stream. It sits between the image RAMs and the pixel-processing datapath (e.g. the subtractor), replacing CPU-driven reads for bulk image traversal. A small credit-controlled FIFO absorbs memory read latency so downstream backpressure never loses data.

## Interface
- ADDR_W, 17, memory word-address width
- DATA_W, 8, pixel width
- NUM_PIXELS, 81920, memory depth; address wraps to 0 after NUM_PIXELS-1
- READ_LATENCY, 1, cycles from address-sampling edge to readdata valid (1 = unregistered q, 2 = registered q)
- FIFO_DEPTH, 4, output FIFO entries; must be >= READ_LATENCY+2

- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a run when idle
- abort  in  1  synchronous cancel of current run
- base_addr  in  ADDR_W  first pixel address (< NUM_PIXELS), sampled on start
- pixel_count  in  ADDR_W  number of pixels, sampled on start; 0 allowed
- busy  out  1  high from accepted start until done/abort
- done  out  1  one-cycle pulse after last pixel accepted downstream
- mem_address  out  ADDR_W  slave address
- mem_chipselect  out  1  high in cycles whose address is a wanted read (issue)
- mem_clken  out  1  constant 1 out of reset
- mem_write  out  1  constant 0
- mem_writedata  out  DATA_W  constant 0
- mem_readdata  in  DATA_W  slave read data
- out_data  out  DATA_W  pixel
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_last  out  1  marks final pixel of run, qualified by out_valid

## Operation
- States: IDLE, RUN, DRAIN. Reset → IDLE; all outputs 0, FIFO empty, counters 0.
- IDLE: start with pixel_count>0 → RUN, latch base/count, busy=1. start with pixel_count=0 → done pulse next cycle, no reads, stays IDLE. start while busy ignored.
- RUN: issue = (issued < count) & (fifo_occupancy + in_flight < FIFO_DEPTH). On issue: mem_chipselect=1, mem_address=current address; address increments, NUM_PIXELS-1 → 0. When issued==count → DRAIN.
- In-flight tracking: READ_LATENCY-stage shift of issue flag; when flag exits, mem_readdata is pushed into FIFO. Credit rule guarantees FIFO never overflows.
- DRAIN: no issues; when in_flight=0, FIFO empty, and last beat accepted → done=1 one cycle, busy=0, IDLE.
- out_last=1 on the beat whose index = count-1.
- abort (any state): next edge → IDLE, FIFO flushed, in-flight data discarded, busy=0, out_valid=0, no done pulse. abort and start same cycle: abort wins.
- Counters ADDR_W+1 bits wide internally; no overflow for max count.

## Timing
- start sampled at edge 0 → address=base, chipselect=1 during cycle 0→1.
- READ_LATENCY=1: readdata pushed at edge 2; out_valid high from edge 2. Latency start→first out_valid = 1+READ_LATENCY edges.
- With out_ready=1 continuously: one pixel per cycle sustained, no bubbles after first.
- out_data/out_valid stable while out_valid & ~out_ready.
- done asserted the cycle after the edge accepting out_last beat.
- reset_n low mid-run: all state cleared immediately, asynchronously; outputs 0.

## Test plan
- Memory preloaded mem[a]=a[7:0]; base=0x00010, count=4, out_ready=1 → out_data 0x10,0x11,0x12,0x13 on consecutive cycles, first out_valid 2 edges after start, out_last on 0x13, done one cycle later.
- Wrap: base=81918, count=4 → mem_address sequence 81918, 81919, 0, 1; data 0xFE,0xFF,0x00,0x01.
- Backpressure: count=16, out_ready low 5 cycles after 3rd beat → chipselect stops once occupancy+in_flight=4; all 16 values delivered in order, none duplicated.
- count=0 → done pulse next cycle, mem_chipselect never high, out_valid never high.
- abort at 6th beat of count=20 → busy=0 next edge, out_valid=0, no done; new start base=0 count=2 → delivers 0x00,0x01 only.
- reset_n pulsed low mid-run; start during busy ignored → all outputs 0 during reset; ignored start causes no change in address sequence or count.
